// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: byte FIFOs between the host side and uart_top's tx/rx strobe interface.
// A TX FIFO is drained one byte at a time into uart_top, paced by tx_busy.
// An RX FIFO captures received bytes, is read show-ahead, and sets a sticky overrun flag.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             host_wr_data,
  input  logic                   host_wr_en,
  output logic                   tx_full,
  output logic                   tx_empty,
  output logic [$clog2(DEPTH):0] tx_count,
  input  logic                   host_rd_en,
  output logic [7:0]             host_rd_data,
  output logic                   rx_empty,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   rx_overrun,
  input  logic                   overrun_clr,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_new_tx,
  input  logic                   uart_tx_busy,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_new_rx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [CW-1:0] tx_count_nxt_c;
  logic          tx_push_c;
  logic          tx_pop_c;

  // A push is accepted when there is room, or when the drain frees a slot in the same cycle.
  always_comb begin
    tx_push_c      = host_wr_en && (!tx_full || tx_pop_c);
    tx_count_nxt_c = tx_count + CW'(tx_push_c) - CW'(tx_pop_c);
  end

  // TX storage; when full with a same-cycle pop, the head is read before it is overwritten.
  always_ff @(posedge clock) begin
    if (tx_push_c) begin
      tx_mem[tx_wr_ptr] <= host_wr_data;
    end
  end

  // TX pointers, occupancy and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_full   <= 1'b0;
      tx_empty  <= 1'b1;
    end else begin
      if (tx_push_c) begin
        tx_wr_ptr <= tx_wr_ptr + AW'(1);
      end
      if (tx_pop_c) begin
        tx_rd_ptr <= tx_rd_ptr + AW'(1);
      end
      tx_count <= tx_count_nxt_c;
      tx_full  <= (tx_count_nxt_c == CW'(DEPTH));
      tx_empty <= (tx_count_nxt_c == '0);
    end
  end

  // ---------------------------------------------------------------- drain FSM
  state_t state;
  state_t state_nxt;

  // Next-state logic; the only pop of the TX FIFO happens on the IDLE -> LAUNCH transition.
  always_comb begin
    state_nxt = state;
    tx_pop_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_empty && !uart_tx_busy) begin
          state_nxt = S_LAUNCH;
          tx_pop_c  = 1'b1;
        end
      end
      S_LAUNCH: state_nxt = S_SETTLE;
      // Guard cycle so uart_top's registered tx_busy has risen before WAIT samples it.
      S_SETTLE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!uart_tx_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register plus the registered byte/strobe handed to uart_top.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      uart_new_tx  <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      state       <= state_nxt;
      uart_new_tx <= tx_pop_c;
      if (tx_pop_c) begin
        uart_tx_data <= tx_mem[tx_rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [CW-1:0] rx_count_nxt_c;
  logic          rx_full;
  logic          rx_push_c;
  logic          rx_pop_c;
  logic          rx_drop_c;

  // RX handshake: a read frees a slot for a same-cycle strobe; otherwise a strobe into a full FIFO is lost.
  always_comb begin
    rx_pop_c       = host_rd_en && !rx_empty;
    rx_push_c      = uart_new_rx && (!rx_full || rx_pop_c);
    rx_drop_c      = uart_new_rx && rx_full && !rx_pop_c;
    rx_count_nxt_c = rx_count + CW'(rx_push_c) - CW'(rx_pop_c);
  end

  // RX storage.
  always_ff @(posedge clock) begin
    if (rx_push_c) begin
      rx_mem[rx_wr_ptr] <= uart_rx_data;
    end
  end

  // RX pointers, occupancy, status flags and the sticky overrun flag (a new drop beats a clear).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      rx_full    <= 1'b0;
      rx_empty   <= 1'b1;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push_c) begin
        rx_wr_ptr <= rx_wr_ptr + AW'(1);
      end
      if (rx_pop_c) begin
        rx_rd_ptr <= rx_rd_ptr + AW'(1);
      end
      rx_count <= rx_count_nxt_c;
      rx_full  <= (rx_count_nxt_c == CW'(DEPTH));
      rx_empty <= (rx_count_nxt_c == '0);
      if (rx_drop_c) begin
        rx_overrun <= 1'b1;
      end else if (overrun_clr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  // Show-ahead read port: the head byte is visible whenever the FIFO is not empty.
  assign host_rd_data = rx_mem[rx_rd_ptr];

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: scoreboard bench with queue-based reference model and a uart_top busy model.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] host_wr_data;
  logic       host_wr_en;
  logic       tx_full;
  logic       tx_empty;
  logic [4:0] tx_count;
  logic       host_rd_en;
  logic [7:0] host_rd_data;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       rx_overrun;
  logic       overrun_clr;
  logic [7:0] uart_tx_data;
  logic       uart_new_tx;
  logic       uart_tx_busy = 1'b0;
  logic [7:0] uart_rx_data;
  logic       uart_new_rx;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .host_wr_data (host_wr_data),
    .host_wr_en   (host_wr_en),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_count     (tx_count),
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
    .rx_empty     (rx_empty),
    .rx_count     (rx_count),
    .rx_overrun   (rx_overrun),
    .overrun_clr  (overrun_clr),
    .uart_tx_data (uart_tx_data),
    .uart_new_tx  (uart_new_tx),
    .uart_tx_busy (uart_tx_busy),
    .uart_rx_data (uart_rx_data),
    .uart_new_rx  (uart_new_rx)
  );

  always #5 clock = ~clock;

  // Counters and reference model state.
  int         checks = 0;
  int         errors = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] rdq[$];
  bit         ovr_m = 1'b0;
  int         exp_rxc = 0;
  bit         exp_ovr = 1'b0;
  bit         chk_en = 1'b0;
  int         tx_pushed = 0;
  int         pulses_seen = 0;
  bit         busy_hold = 1'b0;
  int         busy_cnt = 0;
  bit         prev_ntx = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances to the state the DUT should show after the next edge.
  task automatic cyc(input bit wr, input logic [7:0] wd, input bit nrx, input logic [7:0] rxd,
                     input bit rd, input bit clr);
    bit pop;
    bit push;
    @(negedge clock);
    exp_rxc      = rxq.size();
    exp_ovr      = ovr_m;
    host_wr_en   = wr;
    host_wr_data = wd;
    uart_new_rx  = nrx;
    uart_rx_data = rxd;
    host_rd_en   = rd;
    overrun_clr  = clr;
    if (wr && (tx_pushed - pulses_seen) < DEPTH) begin
      txq.push_back(wd);
      tx_pushed++;
    end
    pop  = rd && (rxq.size() > 0);
    push = nrx && ((rxq.size() < DEPTH) || pop);
    if (pop) rdq.push_back(rxq.pop_front());
    if (push) rxq.push_back(rxd);
    if (nrx && !push) ovr_m = 1'b1;
    else if (clr) ovr_m = 1'b0;
  endtask

  task automatic idle_sample();
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((txq.size() > 0 || !tx_empty) && g < 1000) begin
      idle_sample();
      g++;
    end
    chk("tx_drain_done", int'(txq.size() == 0 && tx_empty), 1);
    repeat (15) idle_sample();
  endtask

  // uart_top stand-in: tx_busy rises after each new_tx strobe and stays high for 10 cycles.
  always @(negedge clock) begin
    if (uart_new_tx) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
    uart_tx_busy = busy_hold || (busy_cnt > 0);
  end

  // Monitor: compares every launched byte and every RX read against the scoreboard queues.
  always @(negedge clock) begin
    #2;
    if (uart_new_tx) begin
      chk("tx_pulse_single", int'(prev_ntx), 0);
      pulses_seen++;
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte 0x%0h expected no launch at %0t", uart_tx_data, $time);
      end else begin
        chk("tx_data", int'(uart_tx_data), int'(txq.pop_front()));
      end
    end
    prev_ntx = uart_new_tx;
    if (chk_en) begin
      chk("rx_count", int'(rx_count), exp_rxc);
      chk("rx_empty", int'(rx_empty), int'(exp_rxc == 0));
      chk("rx_overrun", int'(rx_overrun), int'(exp_ovr));
      if (host_rd_en && !rx_empty) begin
        if (rdq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got read of 0x%0h expected none at %0t", host_rd_data, $time);
        end else begin
          chk("rx_data", int'(host_rd_data), int'(rdq.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  int         base;
  int         tx_sent;
  int         rx_sent;
  int         guard;
  bit         w;
  bit         n;
  bit         r;
  logic [7:0] d;

  initial begin
    reset_n      = 1'b0;
    host_wr_en   = 1'b0;
    host_wr_data = 8'h00;
    host_rd_en   = 1'b0;
    overrun_clr  = 1'b0;
    uart_new_rx  = 1'b0;
    uart_rx_data = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_tx_empty", int'(tx_empty), 1);
    chk("rst_tx_full", int'(tx_full), 0);
    chk("rst_tx_count", int'(tx_count), 0);
    chk("rst_rx_empty", int'(rx_empty), 1);
    chk("rst_rx_count", int'(rx_count), 0);
    chk("rst_overrun", int'(rx_overrun), 0);
    chk("rst_new_tx", int'(uart_new_tx), 0);
    chk("rst_tx_data", int'(uart_tx_data), 0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_sample();
    chk_en = 1'b1;

    // Single byte: strobe exactly in the second cycle after the write edge.
    cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_sample();
    chk("t1_new_tx_c1", int'(uart_new_tx), 0);
    idle_sample();
    chk("t1_new_tx_c2", int'(uart_new_tx), 1);
    chk("t1_tx_data", int'(uart_tx_data), 8'hA5);
    chk("t1_tx_empty", int'(tx_empty), 1);
    idle_sample();
    chk("t1_new_tx_c3", int'(uart_new_tx), 0);
    repeat (15) idle_sample();

    // Fill TX while busy, overflow write ignored, then drain in order.
    busy_hold = 1'b1;
    base = pulses_seen;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    idle_sample();
    chk("t2_tx_full", int'(tx_full), 1);
    chk("t2_tx_count", int'(tx_count), 16);
    cyc(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_sample();
    chk("t2_tx_count_after_17th", int'(tx_count), 16);
    busy_hold = 1'b0;
    wait_drain();
    chk("t2_pulse_count", pulses_seen - base, 16);

    // RX fill, overflow drop, overrun wins against clear, ordered reads, clear.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    idle_sample();
    chk("t3_rx_count", int'(rx_count), 16);
    chk("t3_no_overrun_yet", int'(rx_overrun), 0);
    cyc(1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0);
    idle_sample();
    chk("t3_overrun_set", int'(rx_overrun), 1);
    cyc(1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b1);
    idle_sample();
    chk("t3_overrun_beats_clr", int'(rx_overrun), 1);
    chk("t3_head", int'(host_rd_data), 8'h30);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle_sample();
    chk("t3_overrun_cleared", int'(rx_overrun), 0);
    chk("t3_rx_empty", int'(rx_empty), 1);

    // RX full with same-cycle read and strobe: accepted, no overrun, new byte last.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0);
    idle_sample();
    chk("t4_rx_count", int'(rx_count), 16);
    chk("t4_no_overrun", int'(rx_overrun), 0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    idle_sample();
    chk("t4_last_byte", int'(host_rd_data), 8'h55);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    idle_sample();
    chk("t4_rx_empty", int'(rx_empty), 1);

    // Random traffic through both FIFOs to exercise pointer wrap.
    tx_sent = 0;
    rx_sent = 0;
    guard   = 0;
    while ((tx_sent < 40 || rx_sent < 40 || rxq.size() > 0) && guard < 3000) begin
      w = (tx_sent < 40) && ((tx_pushed - pulses_seen) < 14) && ($urandom_range(0, 1) == 1);
      n = (rx_sent < 40) && (rxq.size() < DEPTH) && ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      cyc(w, d, n, 8'($urandom), r, 1'b0);
      if (w) tx_sent++;
      if (n) rx_sent++;
      guard++;
    end
    chk("t5_traffic_done", int'(guard < 3000), 1);
    wait_drain();
    chk("t5_tx_count", int'(tx_count), 0);
    chk("t5_rx_count", int'(rx_count), 0);

    // Reset while the drain FSM waits on a busy uart with 5 bytes still queued.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 8'h00, 1'b0, 1'b0);
    idle_sample();
    chk("t6_tx_count_pre", int'(tx_count), 5);
    idle_sample();
    idle_sample();
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_new_tx", int'(uart_new_tx), 0);
    chk("t6_tx_data", int'(uart_tx_data), 0);
    chk("t6_tx_empty", int'(tx_empty), 1);
    chk("t6_tx_full", int'(tx_full), 0);
    chk("t6_tx_count", int'(tx_count), 0);
    chk("t6_rx_empty", int'(rx_empty), 1);
    chk("t6_rx_count", int'(rx_count), 0);
    chk("t6_overrun", int'(rx_overrun), 0);
    txq.delete();
    rxq.delete();
    rdq.delete();
    ovr_m     = 1'b0;
    tx_pushed = pulses_seen;
    base      = pulses_seen;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle_sample();
    chk_en = 1'b1;
    repeat (30) idle_sample();
    chk("t6_no_tx_after_reset", pulses_seen - base, 0);
    chk("t6_tx_empty_after", int'(tx_empty), 1);

    chk("end_rd_queue_empty", rdq.size(), 0);
    chk("end_tx_queue_empty", txq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
